// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM slot arbiter: owner encoding, FSM states,
// and the fixed-priority winner selection.
package sdram_arb_pkg;

   localparam int unsigned OWN_W      = 3;
   localparam int unsigned STAT_W     = 16;
   localparam int unsigned RFSH_CNT_W = 10;

   localparam logic [OWN_W-1:0] OWN_NONE = 3'd0;
   localparam logic [OWN_W-1:0] OWN_CHIP = 3'd1;
   localparam logic [OWN_W-1:0] OWN_CPU  = 3'd2;
   localparam logic [OWN_W-1:0] OWN_HOST = 3'd3;
   localparam logic [OWN_W-1:0] OWN_RFSH = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_e;

   // Urgent refresh > chip > pending refresh > promoted host > cpu > host.
   function automatic logic [OWN_W-1:0] pick_owner(
      input logic rfsh_urgent,
      input logic chip_req,
      input logic rfsh_pend,
      input logic host_prom,
      input logic cpu_req,
      input logic host_req
   );
      if (rfsh_urgent)                return OWN_RFSH;
      else if (chip_req)              return OWN_CHIP;
      else if (rfsh_pend)             return OWN_RFSH;
      else if (host_prom && host_req) return OWN_HOST;
      else if (cpu_req)               return OWN_CPU;
      else if (host_req)              return OWN_HOST;
      else                            return OWN_NONE;
   endfunction

endpackage

// File: rtl/sdram_rfsh_timer.sv
// Free-running refresh interval timer with pending/urgent flags; clr consumes a
// refresh without disturbing the timer phase.
module sdram_rfsh_timer
   import sdram_arb_pkg::*;
#(
   parameter int unsigned RFSH_PERIOD = 895
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic pend,
   output logic urgent
);

   logic [RFSH_CNT_W-1:0] cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  urgent_q, urgent_d;
   logic                  wrap_c;

   // A wrap coinciding with clr re-arms only pend, since the old refresh is being served.
   always_comb begin
      wrap_c   = (cnt_q == RFSH_CNT_W'(RFSH_PERIOD - 1));
      cnt_d    = wrap_c ? '0 : cnt_q + RFSH_CNT_W'(1);
      pend_d   = pend_q;
      urgent_d = urgent_q;
      if (clr) begin
         pend_d   = 1'b0;
         urgent_d = 1'b0;
      end
      if (wrap_c) begin
         if (pend_d) urgent_d = 1'b1;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         urgent_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         urgent_q <= urgent_d;
      end
   end

   assign pend   = pend_q;
   assign urgent = urgent_q;

endmodule

// File: rtl/sdram_slot_arb.sv
// SDRAM slot arbiter: grants one slot at a time to chip, cpu, host or refresh.
// Optional grant counters are built when SDRAM_SLOT_ARB_STATS_EN is defined.
module sdram_slot_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned RFSH_PERIOD   = 895,
   parameter int unsigned HOST_MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chip_req,
   input  logic              cpu_req,
   input  logic              host_req,
   output logic              chip_gnt,
   output logic              cpu_gnt,
   output logic              host_gnt,
   output logic              slot_start,
   output logic [OWN_W-1:0]  slot_owner,
   input  logic              slot_done,
   output logic              rfsh_urgent,
   output logic [STAT_W-1:0] stat_chip,
   output logic [STAT_W-1:0] stat_cpu,
   output logic [STAT_W-1:0] stat_host,
   output logic [STAT_W-1:0] stat_rfsh
);

   localparam int unsigned HW_W = $clog2(HOST_MAX_WAIT + 1);

   arb_state_e       state_q, state_d;
   logic [OWN_W-1:0] owner_q, owner_d;
   logic [OWN_W-1:0] win_c;
   logic [HW_W-1:0]  host_wait_q, host_wait_d;
   logic             slot_start_q, slot_start_d;
   logic             chip_gnt_q, chip_gnt_d;
   logic             cpu_gnt_q, cpu_gnt_d;
   logic             host_gnt_q, host_gnt_d;
   logic             rfsh_pend, rfsh_urg, rfsh_clr;
   logic             host_prom_c, any_req_c;

   // The refresh being started consumes the pending/urgent flags.
   assign rfsh_clr = slot_start_q && (owner_q == OWN_RFSH);

   sdram_rfsh_timer #(
      .RFSH_PERIOD (RFSH_PERIOD)
   ) u_rfsh (
      .clk    (clk),
      .rst    (rst),
      .clr    (rfsh_clr),
      .pend   (rfsh_pend),
      .urgent (rfsh_urg)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      host_wait_d  = host_wait_q;
      slot_start_d = 1'b0;
      host_prom_c  = (host_wait_q == HW_W'(HOST_MAX_WAIT));
      any_req_c    = chip_req || cpu_req || host_req || rfsh_pend || rfsh_urg;
      win_c        = pick_owner(rfsh_urg, chip_req, rfsh_pend, host_prom_c, cpu_req, host_req);

      case (state_q)
         ST_IDLE: begin
            if (any_req_c) begin
               state_d      = ST_GRANT;
               owner_d      = win_c;
               slot_start_d = 1'b1;
               if (win_c == OWN_HOST) begin
                  host_wait_d = '0;
               end else if (host_req && !host_prom_c) begin
                  host_wait_d = host_wait_q + HW_W'(1);
               end
            end
         end
         ST_GRANT: state_d = ST_BUSY;
         ST_BUSY: begin
            if (slot_done) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      chip_gnt_d = (owner_d == OWN_CHIP);
      cpu_gnt_d  = (owner_d == OWN_CPU);
      host_gnt_d = (owner_d == OWN_HOST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_NONE;
         host_wait_q  <= '0;
         slot_start_q <= 1'b0;
         chip_gnt_q   <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         host_gnt_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         host_wait_q  <= host_wait_d;
         slot_start_q <= slot_start_d;
         chip_gnt_q   <= chip_gnt_d;
         cpu_gnt_q    <= cpu_gnt_d;
         host_gnt_q   <= host_gnt_d;
      end
   end

   assign chip_gnt    = chip_gnt_q;
   assign cpu_gnt     = cpu_gnt_q;
   assign host_gnt    = host_gnt_q;
   assign slot_start  = slot_start_q;
   assign slot_owner  = owner_q;
   assign rfsh_urgent = rfsh_urg;

`ifdef SDRAM_SLOT_ARB_STATS_EN
   logic [STAT_W-1:0] stat_chip_q, stat_chip_d;
   logic [STAT_W-1:0] stat_cpu_q, stat_cpu_d;
   logic [STAT_W-1:0] stat_host_q, stat_host_d;
   logic [STAT_W-1:0] stat_rfsh_q, stat_rfsh_d;

   // Count each grant in the cycle it is decided; counters wrap.
   always_comb begin
      stat_chip_d = stat_chip_q;
      stat_cpu_d  = stat_cpu_q;
      stat_host_d = stat_host_q;
      stat_rfsh_d = stat_rfsh_q;
      if (slot_start_d) begin
         case (owner_d)
            OWN_CHIP: stat_chip_d = stat_chip_q + STAT_W'(1);
            OWN_CPU:  stat_cpu_d  = stat_cpu_q + STAT_W'(1);
            OWN_HOST: stat_host_d = stat_host_q + STAT_W'(1);
            OWN_RFSH: stat_rfsh_d = stat_rfsh_q + STAT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_chip_q <= '0;
         stat_cpu_q  <= '0;
         stat_host_q <= '0;
         stat_rfsh_q <= '0;
      end else begin
         stat_chip_q <= stat_chip_d;
         stat_cpu_q  <= stat_cpu_d;
         stat_host_q <= stat_host_d;
         stat_rfsh_q <= stat_rfsh_d;
      end
   end

   assign stat_chip = stat_chip_q;
   assign stat_cpu  = stat_cpu_q;
   assign stat_host = stat_host_q;
   assign stat_rfsh = stat_rfsh_q;
`else
   assign stat_chip = '0;
   assign stat_cpu  = '0;
   assign stat_host = '0;
   assign stat_rfsh = '0;
`endif

endmodule

// File: tb/tb_sdram_slot_arb.sv
// Directed bench for sdram_slot_arb with a short refresh period and host wait limit;
// the bench plays the SDRAM sequencer by answering each slot_start with slot_done.
module tb_sdram_slot_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        chip_req, cpu_req, host_req;
   logic        chip_gnt, cpu_gnt, host_gnt;
   logic        slot_start;
   logic [2:0]  slot_owner;
   logic        slot_done;
   logic        rfsh_urgent;
   logic [15:0] stat_chip, stat_cpu, stat_host, stat_rfsh;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int seq_len = 1;
   int seq_cnt = 0;
   bit seq_auto = 1'b0;

   always #5 clk = ~clk;

   sdram_slot_arb #(
      .RFSH_PERIOD   (32),
      .HOST_MAX_WAIT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .chip_req    (chip_req),
      .cpu_req     (cpu_req),
      .host_req    (host_req),
      .chip_gnt    (chip_gnt),
      .cpu_gnt     (cpu_gnt),
      .host_gnt    (host_gnt),
      .slot_start  (slot_start),
      .slot_owner  (slot_owner),
      .slot_done   (slot_done),
      .rfsh_urgent (rfsh_urgent),
      .stat_chip   (stat_chip),
      .stat_cpu    (stat_cpu),
      .stat_host   (stat_host),
      .stat_rfsh   (stat_rfsh)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      slot_done = 1'b0;
      if (seq_auto) begin
         if (slot_start) begin
            seq_cnt = seq_len;
         end else if (seq_cnt != 0) begin
            seq_cnt--;
            if (seq_cnt == 0) slot_done = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      chip_req  = 1'b0;
      cpu_req   = 1'b0;
      host_req  = 1'b0;
      slot_done = 1'b0;
      seq_auto  = 1'b0;
      seq_cnt   = 0;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic run_to(input int target, output int starts);
      starts = 0;
      while (cyc < target) begin
         tick();
         if (slot_start) starts++;
      end
   endtask

   task automatic wait_start(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (slot_start) ok = 1'b1;
      end
   endtask

   logic        ok;
   int          starts;
   int          first_at;
   logic [2:0]  exp_own [10];
   logic [15:0] exp_cpu_cnt, exp_host_cnt;

   initial begin
      // Reset state
      do_reset();
      rst = 1'b1;
      tick();
      chk("rst_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b000);
      chk("rst_start", slot_start, 1'b0);
      chk("rst_owner", slot_owner, 3'd0);
      chk("rst_urgent", rfsh_urgent, 1'b0);
      chk("rst_stats", {stat_chip, stat_cpu, stat_host, stat_rfsh}, 0);

      // cpu alone; slot_done outside BUSY ignored; dropped request does not end slot
      do_reset();
      slot_done = 1'b1;
      tick();
      chk("idle_done_start", slot_start, 1'b0);
      chk("idle_done_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b000);
      cpu_req = 1'b1;
      tick();
      chk("cpu_start", slot_start, 1'b1);
      chk("cpu_owner", slot_owner, 3'd2);
      chk("cpu_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b010);
      cpu_req   = 1'b0;
      slot_done = 1'b1;
      tick();
      chk("cpu_start_pulse", slot_start, 1'b0);
      tick();
      tick();
      chk("cpu_gnt_held", {chip_gnt, cpu_gnt, host_gnt}, 3'b010);
      chk("cpu_owner_held", slot_owner, 3'd2);
      slot_done = 1'b1;
      tick();
      chk("cpu_done_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b000);
      chk("cpu_done_owner", slot_owner, 3'd0);
      tick();
      chk("cpu_no_restart", slot_start, 1'b0);
`ifdef SDRAM_SLOT_ARB_STATS_EN
      exp_cpu_cnt = 16'd1;
`else
      exp_cpu_cnt = 16'd0;
`endif
      chk("cpu_stat", stat_cpu, exp_cpu_cnt);

      // chip beats cpu, cpu follows after slot_done
      do_reset();
      chip_req = 1'b1;
      cpu_req  = 1'b1;
      seq_auto = 1'b1;
      seq_len  = 3;
      wait_start(10, ok);
      chk("chip_first_seen", ok, 1'b1);
      chk("chip_first_owner", slot_owner, 3'd1);
      chk("chip_first_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b100);
      chk("chip_first_cyc", cyc, 1);
      chip_req = 1'b0;
      wait_start(10, ok);
      chk("cpu_second_seen", ok, 1'b1);
      chk("cpu_second_owner", slot_owner, 3'd2);
      chk("cpu_second_cyc", cyc, 6);

      // idle refresh cadence with period 32
      do_reset();
      seq_auto = 1'b1;
      seq_len  = 2;
      run_to(32, starts);
      chk("rfsh_none_before", starts, 0);
      tick();
      chk("rfsh1_start", slot_start, 1'b1);
      chk("rfsh1_owner", slot_owner, 3'd4);
      chk("rfsh1_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b000);
      run_to(64, starts);
      chk("rfsh_gap1", starts, 0);
      tick();
      chk("rfsh2_start", slot_start, 1'b1);
      chk("rfsh2_owner", slot_owner, 3'd4);
      run_to(96, starts);
      chk("rfsh_gap2", starts, 0);
      tick();
      chk("rfsh3_start", slot_start, 1'b1);
      chk("rfsh3_owner", slot_owner, 3'd4);
      chk("rfsh_not_urgent", rfsh_urgent, 1'b0);

      // chip hogging: refresh turns urgent at 64 and then pre-empts chip
      do_reset();
      chip_req = 1'b1;
      seq_auto = 1'b1;
      seq_len  = 8;
      run_to(63, starts);
      chk("hog_chip_slots", starts, 7);
      chk("hog_owner", slot_owner, 3'd1);
      chk("hog_urgent_63", rfsh_urgent, 1'b0);
      tick();
      chk("hog_urgent_64", rfsh_urgent, 1'b1);
      wait_start(20, ok);
      chk("hog_rfsh_seen", ok, 1'b1);
      chk("hog_rfsh_owner", slot_owner, 3'd4);
      chk("hog_rfsh_cyc", cyc, 71);
      wait_start(20, ok);
      chk("hog_chip_back", slot_owner, 3'd1);
      chk("hog_urgent_clr", rfsh_urgent, 1'b0);

      // host promotion after four lost slots
      do_reset();
      cpu_req  = 1'b1;
      host_req = 1'b1;
      seq_auto = 1'b1;
      seq_len  = 1;
      exp_own = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
      for (int i = 0; i < 10; i++) begin
         wait_start(10, ok);
         chk($sformatf("prom_seen_%0d", i), ok, 1'b1);
         chk($sformatf("prom_owner_%0d", i), slot_owner, exp_own[i]);
      end
      chk("prom_host_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b001);
`ifdef SDRAM_SLOT_ARB_STATS_EN
      exp_cpu_cnt  = 16'd8;
      exp_host_cnt = 16'd2;
`else
      exp_cpu_cnt  = 16'd0;
      exp_host_cnt = 16'd0;
`endif
      chk("prom_stat_cpu", stat_cpu, exp_cpu_cnt);
      chk("prom_stat_host", stat_host, exp_host_cnt);

      // reset during BUSY abandons the slot
      seq_auto = 1'b0;
      seq_cnt  = 0;
      tick();
      tick();
      chk("busy_before_rst", slot_owner != 3'd0, 1'b1);
      rst = 1'b1;
      tick();
      chk("busy_rst_gnt", {chip_gnt, cpu_gnt, host_gnt}, 3'b000);
      chk("busy_rst_owner", slot_owner, 3'd0);
      chk("busy_rst_start", slot_start, 1'b0);
      chk("busy_rst_stats", {stat_chip, stat_cpu, stat_host, stat_rfsh}, 0);
      rst = 1'b0;
      cyc = 0;
      first_at = 0;
      chk("post_rst_quiet", slot_start, 1'b0);
      tick();
      if (slot_start) first_at = cyc;
      chk("post_rst_first", first_at, 1);
      chk("post_rst_owner", slot_owner, 3'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_slot_arb.md
SDRAM_SLOT_ARB -- requirements
Module: sdram_slot_arb

Interface
REQ-001 Parameter RFSH_PERIOD, default 895, clk cycles between refresh requests (7.8 us at 114.75 MHz).
REQ-002 Parameter HOST_MAX_WAIT, default 16, lost arbitrations before host is promoted above cpu.
REQ-003 clk  in  1  system clock (clk_114 domain); the block's only clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 chip_req  in  1  chip DMA requests an SDRAM slot.
REQ-006 cpu_req  in  1  CPU/cache requests a slot.
REQ-007 host_req  in  1  host bridge requests a slot.
REQ-008 chip_gnt / cpu_gnt / host_gnt  out  1 each  requester owns the current slot.
REQ-009 slot_start  out  1  one-cycle pulse; the SDRAM sequencer begins the slot.
REQ-010 slot_owner  out  3  encoding: 0 none, 1 chip, 2 cpu, 3 host, 4 refresh; valid from slot_start through slot_done.
REQ-011 slot_done  in  1  one-cycle pulse from the sequencer; the slot has completed.
REQ-012 rfsh_urgent  out  1  a refresh has been pending for at least RFSH_PERIOD cycles.
REQ-013 stat_chip / stat_cpu / stat_host / stat_rfsh  out  16 each  grant counters (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, GRANT and BUSY; transitions are IDLE->GRANT if any request is pending, GRANT->BUSY unconditionally, and BUSY->IDLE on slot_done.
REQ-015 In IDLE, the arbiter SHALL sample requests and latch the winner into slot_owner.
REQ-016 slot_start SHALL pulse in GRANT; the latency from a request in IDLE to slot_start is 1 cycle.
REQ-017 The matching *_gnt SHALL be high from GRANT until the cycle in which slot_done is sampled, and low at all other times; at most one gnt is high at any time.
REQ-018 Priority SHALL be: urgent refresh > chip > pending refresh > promoted host > cpu > host.
REQ-019 A 10-bit refresh timer SHALL count to RFSH_PERIOD-1, then wrap to 0 and set rfsh_pend; if rfsh_pend is already set at the wrap, it sets rfsh_urgent instead.
REQ-020 A refresh grant SHALL clear both rfsh_pend and rfsh_urgent at slot_start; the timer is never stopped or reset by grants.
REQ-021 Each slot in which host_req is high but host loses SHALL increment host_wait (saturating at HOST_MAX_WAIT); a host grant clears host_wait; the host is promoted when host_wait == HOST_MAX_WAIT.
REQ-022 If slot_done is asserted in IDLE or GRANT, it SHALL be ignored.
REQ-023 A request deasserted while granted SHALL NOT end the slot; only slot_done ends it.
REQ-024 If slot_done arrives in the same cycle as a new request, the FSM SHALL return to IDLE first; there are no back-to-back slot_start pulses closer than 3 cycles.

Reset
REQ-025 While rst is high: FSM=IDLE, all gnt=0, slot_start=0, slot_owner=0, rfsh_pend=0, rfsh_urgent=0, timer=0, host_wait=0, stat_*=0.
REQ-026 Reset during BUSY SHALL abandon the slot immediately; the first grant after reset occurs no earlier than 1 cycle after rst falls.

Configuration
REQ-027 With macro SDRAM_SLOT_ARB_STATS_EN defined, each stat_* SHALL count grants of its owner, 16-bit, wrapping, cleared by rst.
REQ-028 Without SDRAM_SLOT_ARB_STATS_EN, the counters SHALL be absent and every stat_* is tied to 0.

Structure
REQ-029 A shared package sdram_arb_pkg SHALL hold the owner encoding constants (OWN_NONE..OWN_RFSH) and the FSM state type.
REQ-030 The refresh timer and the pend/urgent flags SHALL be the sub-module sdram_rfsh_timer (ports clk, rst, clr, pend, urgent).

Verification
REQ-031 Bench: cpu_req alone -> slot_start 1 cycle later, slot_owner=2, cpu_gnt high until slot_done.
REQ-032 Bench: chip_req and cpu_req together -> chip granted first (owner 1), then cpu (owner 2) after slot_done.
REQ-033 Bench: with RFSH_PERIOD=32 and no traffic -> a refresh grant (owner 4) at cycle 33 after reset, then every 32 cycles after that.
REQ-034 Bench: with RFSH_PERIOD=32, chip_req held continuously and sequencer slots of 10 cycles -> rfsh_urgent at cycle 64, then the next grant is owner 4 ahead of chip.
REQ-035 Bench: cpu_req and host_req held, HOST_MAX_WAIT=4 -> four cpu grants, then one host grant, then the pattern repeats.
REQ-036 Bench: rst asserted mid-BUSY -> next cycle all gnt=0, slot_owner=0, stat_*=0 (with SDRAM_SLOT_ARB_STATS_EN).
